// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-access Wishbone classic initiator with a valid/ready command port, a valid/ready response port and a bus timeout
module wb_cmd_master #(
  parameter int ADDRWIDTH      = 7,
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,
  input  logic [3:0]           cmd_sel_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i,
  output logic                 busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [7:0] TO   = 8'(TIMEOUT_CYCLES);

  logic [1:0] state;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       expired;

  // the cycle that would bring the bus-cycle count up to the limit is the last one allowed
  always_comb begin
    cnt_inc = cnt + 8'd1;
    expired = cnt_inc == TO;
  end

  // command acceptance, bus cycle and response hold; every output is a register
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state          <= IDLE;
      cnt            <= '0;
      cmd_ready_o    <= 1'b1;
      busy_o         <= 1'b0;
      rsp_valid_o    <= 1'b0;
      rsp_dat_o      <= '0;
      rsp_err_o      <= 1'b0;
      WBm_ADR_o      <= '0;
      WBm_CYC_o      <= 1'b0;
      WBm_STB_o      <= 1'b0;
      WBm_WE_o       <= 1'b0;
      WBm_BYTE_STB_o <= '0;
      WBm_DAT_o      <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid_i && cmd_ready_o) begin
          WBm_ADR_o      <= cmd_adr_i;
          WBm_WE_o       <= cmd_we_i;
          WBm_BYTE_STB_o <= cmd_sel_i;
          WBm_DAT_o      <= cmd_we_i ? cmd_dat_i : '0;
          WBm_CYC_o      <= 1'b1;
          WBm_STB_o      <= 1'b1;
          cmd_ready_o    <= 1'b0;
          busy_o         <= 1'b1;
          state          <= BUS;
        end
        BUS: if (WBm_ACK_i || expired) begin
          WBm_CYC_o   <= 1'b0;
          WBm_STB_o   <= 1'b0;
          rsp_dat_o   <= (WBm_ACK_i && !WBm_WE_o) ? WBm_DAT_i : '0;
          rsp_err_o   <= !WBm_ACK_i;
          rsp_valid_o <= 1'b1;
          state       <= RESP;
        end else begin
          cnt <= cnt_inc;
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          cnt         <= '0;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: randomized and directed checks of wb_cmd_master against a register-bank slave and a reference register model
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [6:0]  cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_dat;
  logic [6:0]  adr;
  logic        cyc, stb, we, busy;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [31:0] sdat = '0;
  logic        ack_r = 1'b0, ack_en = 1'b1, ack_force = 1'b0;
  logic        ack;
  logic [31:0] mem [128];
  logic [31:0] ref_m [128];
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ack = ack_r | ack_force;

  wb_cmd_master #(.ADDRWIDTH(7), .DATAWIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .WBm_ADR_o(adr), .WBm_CYC_o(cyc), .WBm_STB_o(stb), .WBm_WE_o(we),
    .WBm_BYTE_STB_o(sel), .WBm_DAT_o(wdat), .WBm_DAT_i(sdat), .WBm_ACK_i(ack),
    .busy_o(busy)
  );

  // register-bank semantics: 0x00/0x01/0x7F read-only, 0x08 is a 12-bit register, byte strobes select lanes
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s, input logic [6:0] a);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (a == 7'h00 || a == 7'h01 || a == 7'h7F) return old;
    return (a == 7'h08) ? (((old & ~m) | (d & m)) & 32'h0000_0FFF) : ((old & ~m) | (d & m));
  endfunction

  // registered-ACK slave: one ACK per strobed access, data registered with it
  always @(posedge clk) begin
    ack_r <= cyc & stb & ~ack_r & ack_en;
    if (cyc & stb & ~ack_r & ack_en) begin
      sdat <= mem[adr];
      if (we) mem[adr] <= merge(mem[adr], wdat, sel, adr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic w, input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int hold, output logic [31:0] rd, output logic re,
                      output int lat, output int cyc_n);
    int n;
    logic bad;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (!cmd_ready) begin errors++; $display("FAIL cmd_handshake: cmd_ready=%b required 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1; cyc_n = 0; bad = 1'b0;
    vectors++;
    if (adr !== a || we !== w || sel !== s || wdat !== (w ? d : 32'h0) || cyc !== 1'b1 || stb !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL bus_drive: adr=%h we=%b sel=%h dat=%h cyc=%b stb=%b rdy=%b required adr=%h we=%b sel=%h dat=%h cyc=1 stb=1 rdy=0",
               adr, we, sel, wdat, cyc, stb, cmd_ready, a, w, s, w ? d : 32'h0);
    end
    while (!rsp_valid && lat < 400) begin
      cyc_n += int'(cyc);
      if (cyc && (stb !== 1'b1 || adr !== a || we !== w || sel !== s || wdat !== (w ? d : 32'h0))) bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (bad || !rsp_valid) begin
      errors++;
      $display("FAIL bus_hold: unstable=%b rsp_valid=%b required unstable=0 rsp_valid=1", bad, rsp_valid);
    end
    rd = rsp_dat; re = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_dat !== rd || rsp_err !== re || cmd_ready !== 1'b0 || cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rsp_hold: valid=%b dat=%h err=%b rdy=%b cyc=%b stb=%b busy=%b required 1 %h %b 0 0 0 1",
                 rsp_valid, rsp_dat, rsp_err, cmd_ready, cyc, stb, busy, rd, re);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rsp_release: valid=%b rdy=%b busy=%b required 0 1 0", rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_dat !== 32'h0 || rsp_err !== 1'b0 || adr !== 7'h0 ||
        cyc !== 1'b0 || stb !== 1'b0 || we !== 1'b0 || sel !== 4'h0 || wdat !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b valid=%b dat=%h err=%b adr=%h cyc=%b stb=%b we=%b sel=%h wdat=%h busy=%b required rdy=1 rest 0",
               cmd_ready, rsp_valid, rsp_dat, rsp_err, adr, cyc, stb, we, sel, wdat, busy);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || cyc !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b busy=%b cyc=%b required 1 0 0", cmd_ready, busy, cyc);
    end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic re; int lat, cn;
    ref_m[2] = merge(ref_m[2], 32'h0000_1234, 4'b0011, 7'h02);
    send(1'b1, 7'h02, 32'h0000_1234, 4'b0011, 0, rd, re, lat, cn);
    vectors++;
    if (rd !== 32'h0 || re !== 1'b0 || lat !== 3 || cn !== 2) begin
      errors++; $display("FAIL write_0x02: dat=%h err=%b lat=%0d cyc=%0d required 0 0 3 2", rd, re, lat, cn);
    end
    send(1'b0, 7'h02, 32'h0, 4'b1111, 0, rd, re, lat, cn);
    vectors++;
    if (rd !== 32'h0000_1234 || rd !== ref_m[2] || re !== 1'b0 || lat !== 3 || cn !== 2) begin
      errors++; $display("FAIL read_0x02: dat=%h err=%b lat=%0d cyc=%0d required 00001234 0 3 2", rd, re, lat, cn);
    end
  endtask

  task automatic test_fixed_regs;
    logic [6:0]  ta [3] = '{7'h00, 7'h01, 7'h7F};
    logic [31:0] td [3] = '{32'h0000_A5BD, 32'h0000_0100, 32'hFABD_EFAC};
    logic [31:0] rd; logic re; int lat, cn;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, ta[i], 32'h0, 4'b1111, 0, rd, re, lat, cn);
      vectors++;
      if (rd !== td[i] || re !== 1'b0 || lat !== 3) begin
        errors++; $display("FAIL fixed_read_%h: dat=%h err=%b lat=%0d required %h 0 3", ta[i], rd, re, lat, td[i]);
      end
    end
  endtask

  task automatic test_masked;
    logic [31:0] wd [2] = '{32'hFFFF_FFFF, 32'h0000_0000};
    logic [3:0]  ws [2] = '{4'b0011, 4'b0001};
    logic [31:0] ex [2] = '{32'h0000_0FFF, 32'h0000_0F00};
    logic [31:0] rd; logic re; int lat, cn;
    for (int i = 0; i < 2; i++) begin
      ref_m[8] = merge(ref_m[8], wd[i], ws[i], 7'h08);
      send(1'b1, 7'h08, wd[i], ws[i], 0, rd, re, lat, cn);
      send(1'b0, 7'h08, 32'h0, 4'b1111, 0, rd, re, lat, cn);
      vectors++;
      if (rd !== ex[i] || rd !== ref_m[8] || re !== 1'b0) begin
        errors++; $display("FAIL masked_read_%0d: dat=%h err=%b required %h 0", i, rd, re, ex[i]);
      end
    end
  endtask

  task automatic test_timeout;
    logic [31:0] rd; logic re; int lat, cn;
    ack_en = 1'b0;
    send(1'b0, 7'h05, 32'h0, 4'b1111, 0, rd, re, lat, cn);
    vectors++;
    if (cn !== 16 || re !== 1'b1 || rd !== 32'h0 || lat !== 17) begin
      errors++; $display("FAIL timeout_read: cyc=%0d err=%b dat=%h lat=%0d required 16 1 0 17", cn, re, rd, lat);
    end
    send(1'b1, 7'h03, 32'hDEAD_BEEF, 4'b1111, 0, rd, re, lat, cn);
    vectors++;
    if (cn !== 16 || re !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL timeout_write: cyc=%0d err=%b dat=%h required 16 1 0", cn, re, rd);
    end
    ack_en = 1'b1;
    send(1'b0, 7'h00, 32'h0, 4'b1111, 0, rd, re, lat, cn);
    vectors++;
    if (rd !== 32'h0000_A5BD || re !== 1'b0 || lat !== 3 || cn !== 2) begin
      errors++; $display("FAIL after_timeout: dat=%h err=%b lat=%0d cyc=%0d required 0000a5bd 0 3 2", rd, re, lat, cn);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic re; int lat, cn;
    send(1'b0, 7'h7F, 32'h0, 4'b1111, 5, rd, re, lat, cn);
    vectors++;
    if (rd !== 32'hFABD_EFAC || re !== 1'b0) begin
      errors++; $display("FAIL backpressure_read: dat=%h err=%b required fabdefac 0", rd, re);
    end
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (cyc !== 1'b0 || stb !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++; $display("FAIL stray_ack: cyc=%b stb=%b valid=%b rdy=%b required 0 0 0 1", cyc, stb, rsp_valid, cmd_ready);
      end
    end
    ack_force = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic re; int lat, cn;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 7'h01; cmd_sel = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    vectors++;
    if (cyc !== 1'b1) begin errors++; $display("FAIL mid_start: cyc=%b required 1", cyc); end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (cyc !== 1'b0 || stb !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: cyc=%b stb=%b valid=%b busy=%b required 0 0 0 0", cyc, stb, rsp_valid, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cyc !== 1'b0) begin
        errors++; $display("FAIL stale_rsp: valid=%b rdy=%b cyc=%b required 0 1 0", rsp_valid, cmd_ready, cyc);
      end
    end
    send(1'b0, 7'h01, 32'h0, 4'b1111, 0, rd, re, lat, cn);
    vectors++;
    if (rd !== 32'h0000_0100 || re !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL after_reset: dat=%h err=%b lat=%0d required 00000100 0 3", rd, re, lat);
    end
  endtask

  task automatic test_random;
    logic [6:0]  pick [5] = '{7'h00, 7'h01, 7'h02, 7'h08, 7'h7F};
    logic [31:0] rd, d, ex; logic re, w; logic [6:0] a; logic [3:0] s; int lat, cn;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 4)] : 7'($urandom_range(0, 127));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if (w) ref_m[a] = merge(ref_m[a], d, s, a);
      ex = w ? 32'h0 : ref_m[a];
      send(w, a, d, s, int'($urandom_range(0, 2)), rd, re, lat, cn);
      vectors++;
      if (rd !== ex || re !== 1'b0 || lat !== 3 || cn !== 2) begin
        errors++; $display("FAIL random_%0d we=%b adr=%h: dat=%h err=%b lat=%0d cyc=%0d required %h 0 3 2",
                           i, w, a, rd, re, lat, cn, ex);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin mem[i] = 32'h0; ref_m[i] = 32'h0; end
    mem[0] = 32'h0000_A5BD; mem[1] = 32'h0000_0100; mem[127] = 32'hFABD_EFAC;
    ref_m[0] = 32'h0000_A5BD; ref_m[1] = 32'h0000_0100; ref_m[127] = 32'hFABD_EFAC;
    repeat (3) @(posedge clk);
    test_reset;
    test_write_read;
    test_fixed_regs;
    test_masked;
    test_timeout;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
